// File: rtl/mod100_bcd_down_counter_pkg.sv
// Shared types and constants for the mod-100 BCD down counter.
// FSM state encoding, count ceiling and BCD digit width.
package mod100_bcd_down_counter_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    PAUSE = 2'd2
  } state_t;

  localparam int MAX_COUNT = 99;
  localparam int DIGIT_W   = 4;

endpackage

// File: rtl/mod100_bcd_down_counter_edge_sync.sv
// Synchroniser plus rising-edge detector for the slow_clk step input.
// Emits a one-cycle step pulse per synchronised rising edge of din.
module mod100_bcd_down_counter_edge_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic din,
  output logic step
);

  logic [SYNC_STAGES-1:0] sync;
  logic [SYNC_STAGES-1:0] vld;
  logic                   hist;
  logic                   hist_vld;

  // vld marks which sync/history bits hold real samples since reset, so a
  // din that is already high at reset release never looks like a new edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync     <= '0;
      vld      <= '0;
      hist     <= 1'b0;
      hist_vld <= 1'b0;
    end else begin
      sync     <= {sync[SYNC_STAGES-2:0], din};
      vld      <= {vld[SYNC_STAGES-2:0], 1'b1};
      hist     <= sync[SYNC_STAGES-1];
      hist_vld <= vld[SYNC_STAGES-1];
    end
  end

  assign step = hist_vld & sync[SYNC_STAGES-1] & ~hist;

endmodule

// File: rtl/mod100_bcd_down_counter.sv
// Mod-100 BCD down counter stepped by synchronised slow_clk rising edges.
// Define MOD100_STOP_AT_ZERO_EN to stop at 00 and return to IDLE instead of wrapping.
module mod100_bcd_down_counter
  import mod100_bcd_down_counter_pkg::*;
#(
  parameter int START_VAL   = 99,
  parameter int SYNC_STAGES = 2
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               slow_clk,
  input  logic               start,
  input  logic               pause,
  input  logic               load,
  input  logic [6:0]         load_val,
  output logic [DIGIT_W-1:0] tens,
  output logic [DIGIT_W-1:0] ones,
  output logic               running,
  output logic               wrap
);

  localparam logic [DIGIT_W-1:0] START_TENS = DIGIT_W'(START_VAL / 10);
  localparam logic [DIGIT_W-1:0] START_ONES = DIGIT_W'(START_VAL % 10);
  localparam logic [DIGIT_W-1:0] DIGIT_MAX  = DIGIT_W'(9);

  function automatic logic [2*DIGIT_W-1:0] bin_to_bcd(input logic [6:0] v);
    logic [6:0] c;
    c = (v > 7'(MAX_COUNT)) ? 7'(MAX_COUNT) : v;
    return {DIGIT_W'(c / 7'd10), DIGIT_W'(c % 7'd10)};
  endfunction

  state_t             state, state_next;
  logic [DIGIT_W-1:0] tens_q, ones_q, tens_next, ones_next;
  logic               wrap_q, wrap_next;
  logic               step;
  logic [2*DIGIT_W-1:0] load_bcd;

  mod100_bcd_down_counter_edge_sync #(
    .SYNC_STAGES(SYNC_STAGES)
  ) u_edge_sync (
    .clk  (clk),
    .rst_n(rst_n),
    .din  (slow_clk),
    .step (step)
  );

  assign load_bcd = bin_to_bcd(load_val);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      tens_q <= START_TENS;
      ones_q <= START_ONES;
      wrap_q <= 1'b0;
    end else begin
      state  <= state_next;
      tens_q <= tens_next;
      ones_q <= ones_next;
      wrap_q <= wrap_next;
    end
  end

  // load beats any FSM transition, and a transition swallows a coincident step.
  always_comb begin
    state_next = state;
    tens_next  = tens_q;
    ones_next  = ones_q;
    wrap_next  = 1'b0;
    if (load) begin
      {tens_next, ones_next} = load_bcd;
    end else begin
      case (state)
        IDLE: if (start) state_next = RUN;
        RUN: begin
          if (pause) begin
            state_next = PAUSE;
          end else if (step) begin
            if (tens_q == '0 && ones_q == '0) begin
              wrap_next = 1'b1;
`ifdef MOD100_STOP_AT_ZERO_EN
              state_next = IDLE;
`else
              tens_next = DIGIT_MAX;
              ones_next = DIGIT_MAX;
`endif
            end else if (ones_q == '0) begin
              ones_next = DIGIT_MAX;
              tens_next = tens_q - 1'b1;
            end else begin
              ones_next = ones_q - 1'b1;
            end
          end
        end
        PAUSE: if (!pause) state_next = RUN;
        default: state_next = IDLE;
      endcase
    end
  end

  assign tens    = tens_q;
  assign ones    = ones_q;
  assign wrap    = wrap_q;
  assign running = (state == RUN);

endmodule

// File: tb/tb_mod100_bcd_down_counter.sv
// Directed self-checking bench for mod100_bcd_down_counter.
// Inputs are driven on falling clk edges; outputs are sampled on falling edges.
module tb_mod100_bcd_down_counter;

  logic       clk = 1'b0;
  logic       rst_n, slow_clk, start, pause, load;
  logic [6:0] load_val;
  logic [3:0] tens, ones;
  logic       running, wrap;

  int checks = 0;
  int passed = 0;
  logic w_at, w_next, r_at;

  mod100_bcd_down_counter #(.START_VAL(99), .SYNC_STAGES(2)) dut (
    .clk(clk), .rst_n(rst_n), .slow_clk(slow_clk), .start(start),
    .pause(pause), .load(load), .load_val(load_val),
    .tens(tens), .ones(ones), .running(running), .wrap(wrap)
  );

  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  // One slow_clk period: rise, let the update land, fall and settle.
  task automatic slow_edge();
    slow_clk = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    w_at = wrap;
    r_at = running;
    slow_clk = 1'b0;
    @(negedge clk);
    w_next = wrap;
    repeat (2) @(negedge clk);
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic do_load(input logic [6:0] v);
    load_val = v;
    load = 1'b1;
    @(negedge clk);
    load = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; slow_clk = 1'b0; start = 1'b0; pause = 1'b0;
    load = 1'b0; load_val = '0;
    repeat (2) @(negedge clk);
    checks++; if ({tens, ones} !== 8'h99) $display("FAIL reset_count got %h want 99", {tens, ones}); else passed++;
    checks++; if (running !== 1'b0) $display("FAIL reset_running got %b want 0", running); else passed++;
    checks++; if (wrap !== 1'b0) $display("FAIL reset_wrap got %b want 0", wrap); else passed++;
    rst_n = 1'b1;
    @(negedge clk);
    slow_edge();
    checks++; if ({tens, ones} !== 8'h99) $display("FAIL idle_step got %h want 99", {tens, ones}); else passed++;
    checks++; if (running !== 1'b0) $display("FAIL idle_running got %b want 0", running); else passed++;
  endtask

  task automatic test_start_pause_idle();
    start = 1'b1; pause = 1'b1;
    @(negedge clk);
    start = 1'b0;
    checks++; if (running !== 1'b1) $display("FAIL sp_run got %b want 1", running); else passed++;
    @(negedge clk);
    checks++; if (running !== 1'b0) $display("FAIL sp_pause got %b want 0", running); else passed++;
    pause = 1'b0;
    @(negedge clk);
    checks++; if (running !== 1'b1) $display("FAIL sp_resume got %b want 1", running); else passed++;
  endtask

  task automatic test_count();
    logic [7:0] exp [3] = '{8'h98, 8'h97, 8'h96};
    pulse_start();
    for (int i = 0; i < 3; i++) begin
      slow_edge();
      checks++; if ({tens, ones} !== exp[i]) $display("FAIL count_%0d got %h want %h", i, {tens, ones}, exp[i]); else passed++;
    end
    checks++; if (running !== 1'b1) $display("FAIL count_running got %b want 1", running); else passed++;
  endtask

  task automatic test_wrap();
    logic [7:0] exp [3] = '{8'h02, 8'h01, 8'h00};
    do_load(7'd3);
    checks++; if ({tens, ones} !== 8'h03) $display("FAIL wrap_load got %h want 03", {tens, ones}); else passed++;
    pulse_start();
    for (int i = 0; i < 3; i++) begin
      slow_edge();
      checks++; if ({tens, ones} !== exp[i] || w_at !== 1'b0) $display("FAIL wrap_down_%0d got %h/%b want %h/0", i, {tens, ones}, w_at, exp[i]); else passed++;
    end
    slow_edge();
`ifdef MOD100_STOP_AT_ZERO_EN
    checks++; if ({tens, ones} !== 8'h00) $display("FAIL wrap_stop got %h want 00", {tens, ones}); else passed++;
    checks++; if (r_at !== 1'b0) $display("FAIL wrap_stop_running got %b want 0", r_at); else passed++;
`else
    checks++; if ({tens, ones} !== 8'h99) $display("FAIL wrap_value got %h want 99", {tens, ones}); else passed++;
    checks++; if (r_at !== 1'b1) $display("FAIL wrap_running got %b want 1", r_at); else passed++;
`endif
    checks++; if (w_at !== 1'b1) $display("FAIL wrap_pulse got %b want 1", w_at); else passed++;
    checks++; if (w_next !== 1'b0) $display("FAIL wrap_width got %b want 0", w_next); else passed++;
  endtask

  task automatic test_timing();
    pulse_start();
    do_load(7'd21);
    slow_clk = 1'b1;
    @(posedge clk); @(negedge clk);
    checks++; if ({tens, ones} !== 8'h21) $display("FAIL timing_k got %h want 21", {tens, ones}); else passed++;
    @(posedge clk); @(negedge clk);
    checks++; if ({tens, ones} !== 8'h21) $display("FAIL timing_k1 got %h want 21", {tens, ones}); else passed++;
    @(posedge clk); @(negedge clk);
    checks++; if ({tens, ones} !== 8'h20) $display("FAIL timing_k2 got %h want 20", {tens, ones}); else passed++;
    slow_clk = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  task automatic test_pause();
    do_load(7'd50);
    pause = 1'b1;
    @(negedge clk);
    checks++; if (running !== 1'b0) $display("FAIL pause_state got %b want 0", running); else passed++;
    for (int i = 0; i < 5; i++) begin
      slow_edge();
      checks++; if ({tens, ones} !== 8'h50) $display("FAIL pause_hold_%0d got %h want 50", i, {tens, ones}); else passed++;
    end
    pause = 1'b0;
    @(negedge clk);
    checks++; if (running !== 1'b1 || {tens, ones} !== 8'h50) $display("FAIL pause_resume got %b/%h want 1/50", running, {tens, ones}); else passed++;
    slow_edge();
    checks++; if ({tens, ones} !== 8'h49) $display("FAIL pause_next got %h want 49", {tens, ones}); else passed++;
  endtask

  task automatic test_load();
    do_load(7'd120);
    checks++; if ({tens, ones} !== 8'h99) $display("FAIL load_clamp got %h want 99", {tens, ones}); else passed++;
    do_load(7'd77);
    checks++; if ({tens, ones} !== 8'h77 || running !== 1'b1) $display("FAIL load_77 got %h/%b want 77/1", {tens, ones}, running); else passed++;
    slow_clk = 1'b1;
    @(posedge clk); @(posedge clk);
    @(negedge clk);
    load_val = 7'd42; load = 1'b1;
    @(negedge clk);
    load = 1'b0;
    checks++; if ({tens, ones} !== 8'h42) $display("FAIL load_step got %h want 42", {tens, ones}); else passed++;
    repeat (3) @(negedge clk);
    checks++; if ({tens, ones} !== 8'h42) $display("FAIL load_step_dropped got %h want 42", {tens, ones}); else passed++;
    slow_clk = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  task automatic test_reset_mid_run();
    do_load(7'd42);
    checks++; if ({tens, ones} !== 8'h42 || running !== 1'b1) $display("FAIL mid_setup got %h/%b want 42/1", {tens, ones}, running); else passed++;
    slow_clk = 1'b1;
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    checks++; if ({tens, ones} !== 8'h99 || running !== 1'b0) $display("FAIL mid_reset got %h/%b want 99/0", {tens, ones}, running); else passed++;
    @(negedge clk);
    rst_n = 1'b1;
    pulse_start();
    repeat (6) @(negedge clk);
    checks++; if ({tens, ones} !== 8'h99 || running !== 1'b1) $display("FAIL mid_no_step got %h/%b want 99/1", {tens, ones}, running); else passed++;
    slow_clk = 1'b0;
    repeat (3) @(negedge clk);
    slow_edge();
    checks++; if ({tens, ones} !== 8'h98) $display("FAIL mid_fresh_edge got %h want 98", {tens, ones}); else passed++;
  endtask

  initial begin
    test_reset();
    test_start_pause_idle();
    test_count();
    test_wrap();
    test_timing();
    test_pause();
    test_load();
    test_reset_mid_run();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule

// File: doc/mod100_bcd_down_counter.md
MOD100_BCD_DOWN_COUNTER -- requirements
Module: mod100_bcd_down_counter

Interface
REQ-001 SHALL have parameter START_VAL, default 99: count value after reset (0..99).
REQ-002 SHALL have parameter SYNC_STAGES, default 2: synchroniser depth on slow_clk (>=2).
REQ-003 SHALL have port clk, input, 1: system clock; all state changes on its rising edge.
REQ-004 SHALL have port rst_n, input, 1: asynchronous, active-low reset.
REQ-005 SHALL have port slow_clk, input, 1: divided clock from the 1 Hz divider, treated as data; each rising edge is one count step.
REQ-006 SHALL have port start, input, 1: pulse; leaves IDLE.
REQ-007 SHALL have port pause, input, 1: level; holds count while high.
REQ-008 SHALL have port load, input, 1: pulse; loads load_val.
REQ-009 SHALL have port load_val, input, 7: unsigned binary load value.
REQ-010 SHALL have port tens, output, 4: BCD tens digit.
REQ-011 SHALL have port ones, output, 4: BCD ones digit.
REQ-012 SHALL have port running, output, 1: high in RUN only.
REQ-013 SHALL have port wrap, output, 1: one-cycle pulse on a 00 step.

Function
REQ-014 SHALL detect slow_clk rising edges via SYNC_STAGES flops plus one history flop; with SYNC_STAGES=2, count updates on the 3rd clk edge sampling slow_clk high.
REQ-015 SHALL implement FSM IDLE, RUN, PAUSE; encoding free.
REQ-016 IDLE: start -> RUN; steps ignored.
REQ-017 RUN: pause high -> PAUSE; start ignored.
REQ-018 PAUSE: pause low -> RUN; steps discarded, not queued.
REQ-019 In RUN, each detected step SHALL decrement count by 1 in BCD: ones 0 -> 9 with tens-1.
REQ-020 At 00, a RUN step SHALL wrap count to 99 and assert wrap for exactly that cycle (default build).
REQ-021 load SHALL set count to load_val converted to BCD in any state; load_val > 99 clamps to 99; state unchanged.
REQ-022 Priority on same cycle: load > FSM transition > step; a step coinciding with load is dropped.
REQ-023 Start and pause asserted together in IDLE SHALL go to RUN; pause takes effect the next cycle.
REQ-024 tens/ones SHALL be registered and never show a non-BCD value (>9).
REQ-025 Edge detector SHALL keep tracking slow_clk in all states so resuming never produces a spurious step.

Reset
REQ-026 rst_n low SHALL immediately force state IDLE, count START_VAL (BCD), running 0, wrap 0, sync/history flops 0.
REQ-027 Reset mid-RUN SHALL abandon any pending step; first step after release requires a fresh slow_clk rising edge.

Configuration
REQ-028 Macro MOD100_STOP_AT_ZERO_EN defined: a RUN step at 00 SHALL keep count 00, pulse wrap, go to IDLE.
REQ-029 Macro undefined: wrap-around per REQ-020; FSM stays in RUN.

Structure
REQ-030 Shared package SHALL hold the FSM state type, MAX_COUNT=99, BCD digit width 4.
REQ-031 Sub-module edge_sync SHALL contain synchroniser plus rising-edge detect, outputting a one-cycle step pulse.
REQ-032 Binary-to-BCD load conversion (0..99) SHALL be combinational inside the top module.

Verification
REQ-033 Reset, start, 3 slow_clk edges -> tens/ones 9/9 -> 9/8 -> 9/7 -> 9/6; running=1.
REQ-034 load 7'd3, start, 4 edges -> 03,02,01,00, then 99 with one-cycle wrap (default); with macro -> 00, wrap, running=0.
REQ-035 In RUN raise pause across 5 edges, drop it -> count unchanged during pause, next edge decrements by exactly 1.
REQ-036 load 7'd120 -> 9/9; load coinciding with a step -> loaded value, no decrement.
REQ-037 rst_n low mid-RUN at count 42 with slow_clk high -> 9/9, IDLE immediately; release with slow_clk still high -> no step.
REQ-038 Step edge timing: slow_clk rises just before clk edge k -> count changes at edge k+2, not earlier.
